// File: rtl/packet_merge_arbiter.sv
// Two-input round-robin merge arbiter on a 4-phase Send/Ack handshake.
// Holds one packet at a time and counts grants per source for debug.
module packet_merge_arbiter #(
  parameter int unsigned PW = 38,
  parameter int unsigned CW = 16
) (
  input  logic          CP,
  input  logic          MR,
  input  logic [PW-1:0] PACKET_IN_a,
  input  logic          Send_in_a,
  output logic          Ack_out_a,
  input  logic [PW-1:0] PACKET_IN_b,
  input  logic          Send_in_b,
  output logic          Ack_out_b,
  output logic [PW-1:0] PACKET_OUT,
  output logic          Send_out,
  input  logic          Ack_in,
  output logic          SRC,
  output logic          BUSY,
  output logic [CW-1:0] GNT_CNT_A,
  output logic [CW-1:0] GNT_CNT_B
);

  typedef enum logic [1:0] {StIdle, StAckUp, StReqDn, StRelDn} state_e;

  state_e state_q, state_d;

  logic          last_q, last_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          send_out_q, send_out_d;
  logic          src_q, src_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] pkt_q, pkt_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d;
  logic [CW-1:0] cnt_b_q, cnt_b_d;

  logic any_req;
  logic win_b;
  logic src_send;

  assign any_req  = Send_in_a | Send_in_b;
  // B wins when alone, or on a tie when A was granted last.
  assign win_b    = Send_in_b & (~Send_in_a | ~last_q);
  assign src_send = src_q ? Send_in_b : Send_in_a;

  // State register
  always_ff @(posedge CP) begin
    if (!MR) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any_req)   state_d = StAckUp;
      StAckUp: if (!src_send) state_d = StReqDn;
      StReqDn: if (Ack_in)    state_d = StRelDn;
      StRelDn: if (!Ack_in)   state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Registered-output next values
  always_comb begin
    last_d     = last_q;
    ack_a_d    = ack_a_q;
    ack_b_d    = ack_b_q;
    send_out_d = send_out_q;
    src_d      = src_q;
    pkt_d      = pkt_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          pkt_d   = win_b ? PACKET_IN_b : PACKET_IN_a;
          src_d   = win_b;
          last_d  = win_b;
          ack_a_d = ~win_b;
          ack_b_d = win_b;
          if (win_b) begin
            cnt_b_d = cnt_b_q + CW'(1);
          end else begin
            cnt_a_d = cnt_a_q + CW'(1);
          end
        end
      end
      StAckUp: begin
        if (!src_send) begin
          ack_a_d    = 1'b0;
          ack_b_d    = 1'b0;
          send_out_d = 1'b1;
        end
      end
      StReqDn: begin
        if (Ack_in) send_out_d = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CP) begin
    if (!MR) begin
      last_q     <= 1'b1;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      send_out_q <= 1'b0;
      src_q      <= 1'b0;
      busy_q     <= 1'b0;
      pkt_q      <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
    end else begin
      last_q     <= last_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
      send_out_q <= send_out_d;
      src_q      <= src_d;
      busy_q     <= busy_d;
      pkt_q      <= pkt_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
    end
  end

  assign Ack_out_a  = ack_a_q;
  assign Ack_out_b  = ack_b_q;
  assign Send_out   = send_out_q;
  assign SRC        = src_q;
  assign BUSY       = busy_q;
  assign PACKET_OUT = pkt_q;
  assign GNT_CNT_A  = cnt_a_q;
  assign GNT_CNT_B  = cnt_b_q;

endmodule

// File: doc/packet_merge_arbiter.md
Name: packet_merge_arbiter

Overview:
- Two-input, one-output merge arbiter for 38-bit dataflow packets on the Send/Ack handshake used between pipeline stages.
- Sits upstream of a branch/lookup stage so two producers (e.g. two function-unit outputs) can share that single stage's input channel.
- Holds one packet at a time in a data latch.
- Arbitrates round-robin and reports per-source grant counts for debug.

Parameters:
- PW, 38, packet width in bits.
- CW, 16, width of each grant counter.

Ports:
- CP  input  1  clock; all state changes on rising edge.
- MR  input  1  reset, synchronous, active-low.
- PACKET_IN_a  input  PW  packet from source A.
- Send_in_a  input  1  source A request.
- Ack_out_a  output  1  acknowledge to source A.
- PACKET_IN_b  input  PW  packet from source B.
- Send_in_b  input  1  source B request.
- Ack_out_b  output  1  acknowledge to source B.
- PACKET_OUT  output  PW  latched packet to downstream stage.
- Send_out  output  1  request to downstream stage.
- Ack_in  input  1  acknowledge from downstream stage.
- SRC  output  1  source of the packet in PACKET_OUT (0=A, 1=B).
- BUSY  output  1  high in every state except IDLE.
- GNT_CNT_A  output  CW  packets granted to A.
- GNT_CNT_B  output  CW  packets granted to B.

Behaviour:
- Reset (MR==0 at a rising CP edge) forces state IDLE and clears every register to 0:
  - Ack_out_a, Ack_out_b, Send_out, PACKET_OUT, SRC, BUSY, GNT_CNT_A, GNT_CNT_B.
  - last-grant pointer LAST is set to 1, so A wins the first tie.
- Reset in any state abandons the held packet. No handshake completes and no counter increments that cycle.
- Handshake on both sides is 4-phase return-to-zero:
  - the sender raises Send with the packet stable;
  - the receiver raises Ack;
  - the sender drops Send;
  - the receiver drops Ack.
- All outputs are registered; nothing is combinational from inputs to outputs.
- FSM states and transitions:
  - IDLE: if only one Send_in_x is high, that source x wins. If both are high, the winner is the source != LAST. On a grant in the same edge:
    - PACKET_OUT <= PACKET_IN_x; SRC <= x; Ack_out_x <= 1; LAST <= x;
    - GNT_CNT_x <= GNT_CNT_x + 1 (wraps modulo 2^CW);
    - go ACK_UP.
    - If neither Send_in_x is high, stay in IDLE.
  - ACK_UP: wait for Send_in_SRC == 0. Then Ack_out_SRC <= 0 and Send_out <= 1 on the same edge; go REQ_DN.
  - REQ_DN: wait for Ack_in == 1. Then Send_out <= 0; go REL_DN.
  - REL_DN: wait for Ack_in == 0; go IDLE.
- BUSY is registered from the next state, so it is high exactly while the state is not IDLE.
- PACKET_OUT holds its value from grant until the next grant. It is not cleared on return to IDLE.
- Latency:
  - Ack_out_x rises 1 cycle after Send_in_x is sampled high in IDLE.
  - Send_out rises 1 cycle after Send_in_x is sampled low in ACK_UP.
  - With zero-delay responders, the full cycle A-request to IDLE is 4 edges, so back-to-back throughput is one packet per 4 cycles minimum.
- The non-winning source's Send_in is ignored until IDLE. Its Ack_out stays 0 and its packet is not sampled.
- Ack_in is ignored in IDLE and ACK_UP; a high value there is a downstream protocol violation and causes no state change. Ack_in sampled 0 in REQ_DN keeps waiting.
- Only one Ack_out_x is ever high, and Ack_out_x and Send_out are never high in the same cycle.
- Counter wrap: at GNT_CNT_x == 2^CW-1, a grant produces 0. There is no saturation and no flag.

Test Plan:
- Reset: hold MR=0 for 2 cycles with Send_in_a=1 -> all outputs 0. First edge after MR=1 grants A: Ack_out_a=1, SRC=0, GNT_CNT_A=1.
- Single transfer: A sends 38'h2A_5555_0001 with a zero-delay downstream -> PACKET_OUT=38'h2A_5555_0001. Ack_out_a high 1 cycle after Send_in_a. Send_out high 1 cycle after Send_in_a drops. Return to IDLE 4 edges after the grant.
- Simultaneous requests: hold Send_in_a=Send_in_b=1 for 4 transfers -> grant order A,B,A,B with SRC=0,1,0,1. GNT_CNT_A=2, GNT_CNT_B=2. Ack_out_b stays 0 during every A transfer.
- Slow downstream: delay Ack_in 5 cycles after Send_out -> Send_out held 5 cycles, PACKET_OUT stable throughout. New Send_in_b is not acknowledged until after REL_DN.
- Spurious Ack_in=1 in IDLE, and again in ACK_UP -> no state change and no Send_out. The transfer later completes normally.
- Mid-transfer reset: MR=0 in REQ_DN -> next edge Send_out=0, BUSY=0, counters=0. Counter wrap, with CW=4 and 16 A grants: GNT_CNT_A returns to 0.
